// File: rtl/data_mem_master_pkg.sv
// Shared types for the data-memory initiator.
//   ADDR_W     : width of request and memory word address
//   MEM_DEPTH  : number of implemented words; addresses >= MEM_DEPTH are out of range
//   bus_type   : 32-bit data bus word
//   mem_addr_t : word address type
//   dm_state_t : initiator FSM state (IDLE -> ISSUE -> RESP -> IDLE)
package data_mem_master_pkg;

  localparam int ADDR_W    = 6;
  localparam int MEM_DEPTH = 32;

  typedef logic [31:0]       bus_type;
  typedef logic [ADDR_W-1:0] mem_addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } dm_state_t;

  // Unsigned compare with one extra bit so MEM_DEPTH == 2**ADDR_W still works.
  // No wrap-around: every address at or above MEM_DEPTH is rejected.
  function automatic logic addr_in_range(input mem_addr_t addr);
    return {1'b0, addr} < (ADDR_W + 1)'(MEM_DEPTH);
  endfunction

endpackage

// File: rtl/data_mem_master.sv
// Initiator side of the data-memory port.
// Takes one load/store at a time from the core, drives the memory for exactly
// one cycle (ISSUE), then holds the response until the core takes it (RESP).
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both 1. valid, once raised, is not required to be held by the core (req side);
// the block holds rsp_valid/rsp_rdata/rsp_err stable until rsp_ready is seen.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   request handshake; req_write 1=store 0=load
//   req_addr          word address
//   req_wdata         store data
//   rsp_valid/ready   response handshake
//   rsp_rdata         load data (0 for stores and errors)
//   rsp_err           address out of range, no memory access performed
//   busy              state != IDLE
//   mem_*             data memory address/data/enables; mem_read_data is a
//                     combinational read of mem_address
//   state_dbg         current FSM state
module data_mem_master
  import data_mem_master_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      req_valid,
  output logic      req_ready,
  input  logic      req_write,
  input  mem_addr_t req_addr,
  input  bus_type   req_wdata,
  output logic      rsp_valid,
  input  logic      rsp_ready,
  output bus_type   rsp_rdata,
  output logic      rsp_err,
  output logic      busy,
  output mem_addr_t mem_address,
  output bus_type   mem_input_data,
  output logic      mem_enable_read,
  output logic      mem_enable_write,
  input  bus_type   mem_read_data,
  output dm_state_t state_dbg
);

  dm_state_t state;
  dm_state_t state_next;

  logic      req_write_q;
  mem_addr_t req_addr_q;
  bus_type   req_wdata_q;
  logic      in_range;
  logic      accept;

  assign in_range = addr_in_range(req_addr_q);
  assign accept   = req_valid && (state == IDLE);

  // State register. Enables are decoded from this, so an asynchronous reset
  // during ISSUE drops them at once and the memory never sees the write edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next       = state;
    req_ready        = 1'b0;
    rsp_valid        = 1'b0;
    mem_enable_read  = 1'b0;
    mem_enable_write = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = ISSUE;
      end
      ISSUE: begin
        mem_enable_read  = in_range && !req_write_q;
        mem_enable_write = in_range &&  req_write_q;
        state_next       = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request register: only loaded on an accepted request, so inputs seen while
  // req_ready is low have no effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
    end else if (accept) begin
      req_write_q <= req_write;
      req_addr_q  <= req_addr;
      req_wdata_q <= req_wdata;
    end
  end

  // Response register: captured at the edge ending ISSUE and held through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (state == ISSUE) begin
      rsp_err   <= !in_range;
      rsp_rdata <= (in_range && !req_write_q) ? mem_read_data : '0;
    end
  end

  assign busy           = (state != IDLE);
  assign mem_address    = req_addr_q;
  assign mem_input_data = req_wdata_q;
  assign state_dbg      = state;

endmodule

// File: tb/tb_data_mem_master.sv
module tb_data_mem_master;
  import data_mem_master_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic      req_valid = 1'b0;
  logic      req_write = 1'b0;
  mem_addr_t req_addr  = '0;
  bus_type   req_wdata = '0;
  logic      rsp_ready = 1'b1;
  logic      req_ready, rsp_valid, rsp_err, busy;
  bus_type   rsp_rdata, mem_input_data, mem_read_data;
  mem_addr_t mem_address;
  logic      mem_enable_read, mem_enable_write;
  dm_state_t state_dbg;

  data_mem_master dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy),
    .mem_address(mem_address), .mem_input_data(mem_input_data),
    .mem_enable_read(mem_enable_read), .mem_enable_write(mem_enable_write),
    .mem_read_data(mem_read_data), .state_dbg(state_dbg)
  );

  // ---------------- data memory stand-in (combinational read, write at edge) ----------------
  bus_type mem [0:MEM_DEPTH-1];
  assign mem_read_data = mem[mem_address[4:0]];
  initial begin
    for (int i = 0; i < MEM_DEPTH; i++) mem[i] = 32'hC0DE_0000 + i;
    forever begin
      @(posedge clk);
      if (mem_enable_write && int'(mem_address) < MEM_DEPTH)
        mem[mem_address[4:0]] <= mem_input_data;
    end
  end

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  bus_type     exp_mem [0:MEM_DEPTH-1];
  logic [32:0] exp_q[$];  // {err, rdata}
  int          accept_cyc  = 0;
  int          last_accept = 0;
  initial for (int i = 0; i < MEM_DEPTH; i++) exp_mem[i] = 32'hC0DE_0000 + i;

  logic prev_re = 1'b0, prev_we = 1'b0, prev_rv = 1'b0;
  int   rd_pulses = 0, wr_pulses = 0;

  always @(negedge clk) begin
    logic [32:0] e;
    check("en_excl", {31'b0, mem_enable_read & mem_enable_write}, 32'd0);
    if (mem_enable_read) begin
      check("rd_width", {31'b0, prev_re}, 32'd0);
      rd_pulses++;
    end
    if (mem_enable_write) begin
      check("wr_width", {31'b0, prev_we}, 32'd0);
      wr_pulses++;
    end
    prev_re = mem_enable_read;
    prev_we = mem_enable_write;
    if (rsp_valid && !prev_rv) check("latency", 32'(cyc - accept_cyc), 32'd2);
    prev_rv = rsp_valid;
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) check("rsp_unexp", 32'(exp_q.size()), 32'd1);
      else begin
        e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, e[31:0]);
        check("rsp_err", {31'b0, rsp_err}, {31'b0, e[32]});
      end
    end
  end

  // ---------------- driver tasks (entered at posedge + 1) ----------------
  task automatic send(input logic w, input mem_addr_t a, input bus_type d, input bit chk_gap);
    int n;
    req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("accept_timeout", {31'b0, req_ready}, 32'd1);
    else begin
      @(posedge clk);
      #1;
      if (int'(a) >= MEM_DEPTH) exp_q.push_back({1'b1, 32'h0});
      else if (w) begin
        exp_q.push_back({1'b0, 32'h0});
        exp_mem[a[4:0]] = d;
      end else exp_q.push_back({1'b0, exp_mem[a[4:0]]});
      if (chk_gap) check("b2b_gap", 32'(cyc - 1 - last_accept), 32'd3);
      last_accept = cyc - 1;
      accept_cyc  = cyc - 1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    while (!(exp_q.size() == 0 && state_dbg == IDLE) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input logic w, input mem_addr_t a, input bus_type d);
    send(w, a, d, 1'b0);
    req_valid = 1'b0;
    drain();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int snap;
    bus_type old3;

    // reset state
    #12;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_mem_addr", 32'(mem_address), 32'd0);
    check("rst_mem_wdata", mem_input_data, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: store then load, range boundary
    txn(1'b1, 6'd5, 32'hDEAD_BEEF);
    txn(1'b0, 6'd5, 32'h0);
    txn(1'b0, 6'd31, 32'h0);
    txn(1'b0, 6'd32, 32'h0);

    // 2: out-of-range load/store never touch the memory enables
    snap = rd_pulses;
    txn(1'b0, 6'd40, 32'h0);
    check("oor_no_rd", 32'(rd_pulses - snap), 32'd0);
    snap = wr_pulses;
    txn(1'b1, 6'd63, 32'h1111_2222);
    check("oor_no_wr", 32'(wr_pulses - snap), 32'd0);

    // 3: response stall with a competing request
    txn(1'b1, 6'd7, 32'h1234_5678);
    rsp_ready = 1'b0;
    send(1'b0, 6'd7, 32'h0, 1'b0);
    req_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    check("stall_rsp_valid_up", {31'b0, rsp_valid}, 32'd1);
    req_write = 1'b1; req_addr = 6'd9; req_wdata = 32'h5555_5555; req_valid = 1'b1;
    snap = wr_pulses;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("stall_rdata", rsp_rdata, 32'h1234_5678);
      check("stall_req_ready", {31'b0, req_ready}, 32'd0);
      check("stall_state", 32'(state_dbg), 32'(RESP));
    end
    check("stall_no_wr", 32'(wr_pulses - snap), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    drain();
    txn(1'b0, 6'd9, 32'h0);

    // 4: reset during ISSUE of a store
    old3 = exp_mem[3];
    send(1'b1, 6'd3, 32'hA5A5_A5A5, 1'b0);
    req_valid = 1'b0;
    check("issue_we_high", {31'b0, mem_enable_write}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_we_async", {31'b0, mem_enable_write}, 32'd0);
    check("rst_re_async", {31'b0, mem_enable_read}, 32'd0);
    check("rst_busy_async", {31'b0, busy}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    exp_mem[3] = old3;
    @(posedge clk); #1;
    txn(1'b0, 6'd3, 32'h0);

    // 5: back-to-back stores then loads
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      send(1'b1, mem_addr_t'(i), $urandom, i != 0);
    for (int i = 0; i < 4; i++)
      send(1'b0, mem_addr_t'(i), 32'h0, 1'b1);
    req_valid = 1'b0;
    drain();

    // a few random transactions across the full address range
    for (int i = 0; i < 12; i++)
      txn(1'($urandom_range(0, 1)), mem_addr_t'($urandom_range(0, 63)), $urandom);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
    $fatal(1, "watchdog");
  end

endmodule
